// File: rtl/axis_frame_streamer.sv
// axis_frame_streamer: generates one IMG_W x IMG_H 8-bit test frame on an AXI-Stream master,
// and on an AXI-Stream slave it consumes the returned frame, counting beats, checking TLAST and summing bytes.
// Latency: the first tx beat comes 1 cycle after start; o_done comes 1 cycle after the later final handshake.
// Backpressure: tx holds tvalid/tdata/tlast stable until tready. rx tready drops once RX_LEN beats are taken.
// Optional macro AXIS_FRAME_STREAMER_THROTTLE_EN adds LFSR-driven gaps on both streams.
module axis_frame_streamer #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int RX_LEN = IMG_W * IMG_H,
    parameter int CNT_W  = $clog2(IMG_W * IMG_H) + 1
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             i_start,
    input  logic [7:0]       i_seed,
    output logic             m_axis_tvalid,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    input  logic             s_axis_tvalid,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tlast_err,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [15:0]      o_checksum
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [CNT_W-1:0] RX_LEN_C  = CNT_W'(RX_LEN);
    localparam logic [CNT_W-1:0] RX_LAST_C = CNT_W'(RX_LEN - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       seed;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             tx_vld;
    logic             tx_done;
    logic [CNT_W-1:0] rx_count;
    logic [15:0]      checksum;
    logic             tlast_err;
    logic             rx_active;
    logic             rx_rdy;
    logic             present_ok;

    logic start_acc;
    logic tx_hs;
    logic tx_at_end;
    logic tx_fin;
    logic rx_hs;
    logic rx_at_end;
    logic rx_fin;

    assign start_acc = (state == IDLE) && i_start;
    assign tx_at_end = (row == ROW_LAST) && (col == COL_LAST);
    assign tx_hs     = tx_vld && m_axis_tready;
    assign tx_fin    = tx_done || (tx_hs && tx_at_end);
    assign rx_hs     = s_axis_tvalid && rx_rdy;
    assign rx_at_end = (rx_count == RX_LAST_C);
    assign rx_fin    = (rx_count == RX_LEN_C) || (rx_hs && rx_at_end);

`ifdef AXIS_FRAME_STREAMER_THROTTLE_EN
    logic [7:0] lfsr;

    // Throttle LFSR: x^8+x^6+x^5+x^4+1, seeded non-zero; it keeps stepping in DRAIN so rx can never freeze
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lfsr <= 8'h00;
        end else if (start_acc) begin
            lfsr <= i_seed | 8'h01;
        end else if (rx_active) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign present_ok = lfsr[0];
    assign rx_rdy     = rx_active && (rx_count < RX_LEN_C) && lfsr[1];
`else
    assign present_ok = 1'b1;
    assign rx_rdy     = rx_active && (rx_count < RX_LEN_C);
`endif

    // FSM state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else              state <= state_nxt;
    end

    // FSM next state: completion uses this cycle's handshakes so o_done lands one cycle after the last one
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (tx_fin) state_nxt = rx_fin ? DONE : DRAIN;
            DRAIN:   if (rx_fin) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        o_busy    = (state == RUN) || (state == DRAIN);
        o_done    = (state == DONE);
        rx_active = (state == RUN) || (state == DRAIN);
    end

    // TX pixel generator: row/col walk the frame, and tvalid holds until the beat is taken
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            seed    <= 8'h00;
            row     <= '0;
            col     <= '0;
            tx_vld  <= 1'b0;
            tx_done <= 1'b0;
        end else if (start_acc) begin
            seed    <= i_seed;
            row     <= '0;
            col     <= '0;
            tx_vld  <= 1'b1;
            tx_done <= 1'b0;
        end else if (state == RUN) begin
            if (tx_hs) begin
                if (tx_at_end) begin
                    tx_vld  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_vld <= present_ok;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end else if (!tx_vld && !tx_done) begin
                tx_vld <= present_ok;
            end
        end
    end

    assign m_axis_tvalid = tx_vld;
    assign m_axis_tdata  = seed + 8'(row) + 8'(col);
    assign m_axis_tlast  = tx_vld && tx_at_end;

    // RX checker: beat count, wrapping byte sum and a sticky TLAST-placement error
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rx_count  <= '0;
            checksum  <= 16'h0000;
            tlast_err <= 1'b0;
        end else if (start_acc) begin
            rx_count  <= '0;
            checksum  <= 16'h0000;
            tlast_err <= 1'b0;
        end else if (rx_hs) begin
            rx_count <= rx_count + 1'b1;
            checksum <= checksum + {8'h00, s_axis_tdata};
            if (s_axis_tlast != rx_at_end) tlast_err <= 1'b1;
        end
    end

    assign s_axis_tready = rx_rdy;
    assign o_rx_count    = rx_count;
    assign o_checksum    = checksum;
    assign o_tlast_err   = tlast_err;

endmodule

// File: tb/tb_axis_frame_streamer.sv
// Bench for axis_frame_streamer with a 4x4 frame: directed vectors with hand-computed results.
// It covers loopback frames with steady and toggling tready, a bad TLAST position, a seed that wraps,
// a start pulse mid-frame, and a reset mid-frame.
module tb_axis_frame_streamer;
    localparam int W = 4;
    localparam int H = 4;
    localparam int CW = $clog2(W * H) + 1;

    logic          axi_clk = 1'b0;
    logic          axi_reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic [7:0]    i_seed = 8'h00;
    logic          m_axis_tvalid;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          s_axis_tvalid;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          o_busy;
    logic          o_done;
    logic          o_tlast_err;
    logic [CW-1:0] o_rx_count;
    logic [15:0]   o_checksum;

    // loop=1 ties tx to rx through rdy_gate; loop=0 uses the manual drivers
    logic       loop = 1'b1;
    logic       rdy_gate = 1'b1;
    logic       m_tready_man = 1'b0;
    logic       s_tvalid_man = 1'b0;
    logic [7:0] s_tdata_man = 8'h00;
    logic       s_tlast_man = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 axi_clk = ~axi_clk;

    always_comb begin
        if (loop) begin
            m_axis_tready = s_axis_tready && rdy_gate;
            s_axis_tvalid = m_axis_tvalid && m_axis_tready;
            s_axis_tdata  = m_axis_tdata;
            s_axis_tlast  = m_axis_tlast;
        end else begin
            m_axis_tready = m_tready_man;
            s_axis_tvalid = s_tvalid_man;
            s_axis_tdata  = s_tdata_man;
            s_axis_tlast  = s_tlast_man;
        end
    end

    axis_frame_streamer #(.IMG_W(W), .IMG_H(H)) dut (
        .axi_clk       (axi_clk),
        .axi_reset_n   (axi_reset_n),
        .i_start       (i_start),
        .i_seed        (i_seed),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_tlast_err   (o_tlast_err),
        .o_rx_count    (o_rx_count),
        .o_checksum    (o_checksum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
        check({tag, "_tready"}, 32'(s_axis_tready), 0);
        check({tag, "_busy"},   32'(o_busy), 0);
        check({tag, "_done"},   32'(o_done), 0);
        check({tag, "_err"},    32'(o_tlast_err), 0);
        check({tag, "_count"},  32'(o_rx_count), 0);
        check({tag, "_sum"},    32'(o_checksum), 0);
    endtask

    // Loopback frame: checks every pixel against seed+row+col, stall stability, done timing and final counts
    task automatic run_frame(input logic [7:0] seed, input bit toggle, input int mid_start, input int exp_sum);
        int beats = 0;
        int cyc = 0;
        int last_hs = -100;
        int dones = 0;
        int done_cyc = -1;
        bit stall_prev = 1'b0;
        bit mid_done = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        logic [7:0] exp_px;
        loop = 1'b1;
        @(negedge axi_clk);
        i_seed = seed;
        i_start = 1'b1;
        rdy_gate = 1'b1;
        @(negedge axi_clk);
        i_start = 1'b0;
        #1;
        check("start_busy", 32'(o_busy), 1);
        check("start_tvalid", 32'(m_axis_tvalid), 1);
        check("start_err_clear", 32'(o_tlast_err), 0);
        while (dones == 0 && cyc < 300) begin
            if (stall_prev) begin
                check("stall_tvalid", 32'(m_axis_tvalid), 1);
                check("stall_tdata", 32'(m_axis_tdata), 32'(pd));
                check("stall_tlast", 32'(m_axis_tlast), 32'(pl));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                exp_px = seed + 8'(beats / W) + 8'(beats % W);
                check("tx_data", 32'(m_axis_tdata), 32'(exp_px));
                check("tx_last", 32'(m_axis_tlast), 32'(beats == W * H - 1));
                beats++;
                last_hs = cyc;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (o_done) begin
                dones++;
                done_cyc = cyc;
                check("done_busy_low", 32'(o_busy), 0);
            end
            @(negedge axi_clk);
            i_start = (mid_start >= 0 && beats == mid_start && !mid_done);
            if (i_start) mid_done = 1'b1;
            if (toggle) rdy_gate = ~rdy_gate;
            #1;
            cyc++;
        end
        i_start = 1'b0;
        check("done_seen", 32'(dones), 1);
        check("done_latency", 32'(done_cyc - last_hs), 1);
        check("tx_beats", 32'(beats), W * H);
        check("rx_count", 32'(o_rx_count), W * H);
        check("checksum", 32'(o_checksum), 32'(exp_sum));
        check("tlast_err", 32'(o_tlast_err), 0);
        @(negedge axi_clk);
        #1;
        check("done_one_cycle", 32'(o_done), 0);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_tvalid", 32'(m_axis_tvalid), 0);
        check("hold_count", 32'(o_rx_count), W * H);
        check("hold_sum", 32'(o_checksum), 32'(exp_sum));
    endtask

    initial begin
        int k;
        int cyc;
        int dones;
        int beats;
        #1;
        check_idle_zero("reset");
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        #1;
        check_idle_zero("post_reset");

        // Steady ready: pixels 0..6, checksum 2*4*(0+1+2+3) = 48
        run_frame(8'h00, 1'b0, -1, 48);
        // tready toggling each cycle: same frame, stalls must hold the beat
        run_frame(8'h00, 1'b1, -1, 48);

        // Manual rx with TLAST on beat 10: bytes 0..15 sum to 120
        loop = 1'b0;
        m_tready_man = 1'b1;
        @(negedge axi_clk);
        i_seed = 8'h00;
        i_start = 1'b1;
        @(negedge axi_clk);
        i_start = 1'b0;
        k = 0;
        cyc = 0;
        dones = 0;
        s_tvalid_man = 1'b1;
        s_tdata_man = 8'd0;
        s_tlast_man = 1'b0;
        #1;
        while (dones == 0 && cyc < 200) begin
            if (s_tvalid_man && s_axis_tready) k++;
            if (o_done) begin
                dones++;
                check("bad_last_err_at_done", 32'(o_tlast_err), 1);
            end
            @(negedge axi_clk);
            s_tvalid_man = (k < W * H);
            s_tdata_man = 8'(k);
            s_tlast_man = (k == 10);
            #1;
            cyc++;
        end
        s_tvalid_man = 1'b0;
        check("bad_last_done_seen", 32'(dones), 1);
        check("bad_last_count", 32'(o_rx_count), W * H);
        check("bad_last_sum", 32'(o_checksum), 120);
        repeat (2) @(negedge axi_clk);
        #1;
        check("bad_last_err_sticky", 32'(o_tlast_err), 1);

        // Seed 0xFE wraps to 0xFE,0xFF,0x00; a start pulse after beat 5 is ignored. Sum of bytes = 784
        run_frame(8'hFE, 1'b0, 5, 784);

        // Reset at beat 7 abandons the frame
        loop = 1'b1;
        rdy_gate = 1'b1;
        @(negedge axi_clk);
        i_seed = 8'h33;
        i_start = 1'b1;
        @(negedge axi_clk);
        i_start = 1'b0;
        #1;
        beats = 0;
        cyc = 0;
        while (beats < 7 && cyc < 100) begin
            if (m_axis_tvalid && m_axis_tready) beats++;
            @(negedge axi_clk);
            #1;
            cyc++;
        end
        check("pre_reset_beats", 32'(beats), 7);
        axi_reset_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        dones = 0;
        repeat (3) begin
            @(negedge axi_clk);
            if (o_done) dones++;
        end
        check("mid_reset_no_done", 32'(dones), 0);
        axi_reset_n = 1'b1;
        // Fresh frame from row 0, col 0: 16*0x10 + 48 = 304
        run_frame(8'h10, 1'b0, -1, 304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axis_frame_streamer.md
Name: axis_frame_streamer

Overview:
- DMA-side counterpart of the Gaussian filter accelerator.
- Its AXI-Stream master generates one IMG_W x IMG_H 8-bit test frame with TLAST, which feeds the accelerator's input slave.
- Its AXI-Stream slave consumes the filtered frame from the accelerator's output master. On that stream it counts beats, checks TLAST placement and accumulates a checksum.
- Raises a one-cycle done pulse per frame. Used for bring-up and as a standalone traffic source/sink in place of the DMA.

Parameters:
IMG_W, 512, pixels per line (>=2)
IMG_H, 512, lines per frame (>=2)
RX_LEN, IMG_W*IMG_H, expected beats in returned frame
CNT_W, $clog2(IMG_W*IMG_H)+1, width of beat counters

Ports:
axi_clk  in  1  single clock
axi_reset_n  in  1  reset; asynchronous, active-low
i_start  in  1  start-frame pulse; sampled only in IDLE
i_seed  in  8  pattern seed, latched on accepted start
m_axis_tvalid  out  1  tx pixel valid
m_axis_tdata  out  8  tx pixel
m_axis_tlast  out  1  tx last pixel of frame
m_axis_tready  in  1  tx backpressure
s_axis_tvalid  in  1  rx pixel valid
s_axis_tdata  in  8  rx pixel
s_axis_tlast  in  1  rx last marker
s_axis_tready  out  1  rx ready
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse, frame complete
o_tlast_err  out  1  sticky TLAST mismatch
o_rx_count  out  CNT_W  rx beats accepted this frame
o_checksum  out  16  wrapping sum of rx bytes this frame

Behaviour:
- Reset (async assert, sync release) forces: all outputs 0; state IDLE; counters, flags and LFSR cleared. Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 -> RUN.
  - Latch i_seed. Clear row/col, rx_count, checksum and o_tlast_err.
  - Set o_busy=1 next cycle.
- RUN (TX):
  - m_axis_tvalid rises the cycle after start.
  - Pixel = (seed + row + col) mod 256.
  - m_axis_tlast=1 only at row=IMG_H-1, col=IMG_W-1.
  - A beat transfers when tvalid & tready.
  - While tvalid=1 and tready=0: tdata, tlast and tvalid hold stable. tvalid never drops without a handshake.
  - col wraps at IMG_W-1 to 0 and increments row.
  - After the last-beat handshake, tvalid=0 and tx_done=1.
- RX (RUN and DRAIN):
  - s_axis_tready=1 while rx_count < RX_LEN, 0 otherwise and in IDLE/DONE.
  - Each rx handshake: rx_count+1; checksum += tdata (16-bit wrap).
  - tlast=1 on beat index != RX_LEN-1, or tlast=0 on beat RX_LEN-1 -> o_tlast_err=1, sticky until next accepted start.
  - rx_done=1 when rx_count reaches RX_LEN.
- Transitions:
  - RUN -> DRAIN when tx_done & !rx_done.
  - RUN -> DONE when tx_done & rx_done. This includes the case where both finish in the same cycle, and the case where rx finishes first.
  - DRAIN -> DONE when rx_done.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 from the same cycle, then -> IDLE.
- Between frames, o_rx_count and o_checksum hold their final values until the next start.
- i_start outside IDLE is ignored.
- Latency: first tx beat is 1 cycle after start. o_done is 1 cycle after the later of the tx-last and rx-last handshakes.

Optional Feature:
- Macro: AXIS_FRAME_STREAMER_THROTTLE_EN
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is loaded with i_seed|8'h01 on start and steps every cycle in RUN.
  - A new tx beat may only be presented when lfsr[0]=1. Once presented, tvalid holds until handshake.
  - s_axis_tready is additionally gated by lfsr[1].
  - Frame content, count and checksum are unchanged.
- Undefined: no LFSR; tvalid is continuous while pixels remain; tready depends only on rx_count.

Test Plan:
- IMG_W=IMG_H=4, seed=0, m_axis_tready=1 -> 16 consecutive beats, data 0,1,2,3,1,2,3,4,...,6; tlast only on beat 15.
- Same config, m_axis_tready toggling 1/0 each cycle -> data/tlast stable across stalls; still exactly 16 beats; no tvalid drop without a handshake.
- tx looped to rx, RX_LEN=16 -> o_rx_count=16, o_checksum=48, o_tlast_err=0; o_done high one cycle, 1 cycle after the last handshake; o_busy falls.
- rx driven with tlast on beat 10 -> o_tlast_err=1 and held through DONE; next i_start clears it to 0.
- seed=0xFE -> first pixels 0xFE, 0xFF, 0x00 (wrap). i_start pulsed mid-frame is ignored: no restart, counts unaffected.
- axi_reset_n low mid-frame (beat 7) -> all outputs 0 immediately, no o_done; after release, start gives a fresh frame from the pixel at row 0, col 0.
